// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and strobes,
// with a mem_ready handshake on the shared instruction/data memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_FETCH   | read instruction at PC, PC <= PC+4 and IR load on mem_ready
// S_DECODE  | decode IR, precompute branch target into ALUOut
// S_MEM_ADR | effective address A + sign-ext for lw/sw
// S_MEM_RD  | data read at ALUOut, wait for mem_ready
// S_MEM_WB  | write MDR into rt
// S_MEM_WR  | data write at ALUOut, wait for mem_ready
// S_R_EX    | R-type ALU operation A op B
// S_R_WB    | write ALUOut into rd
// S_I_EX    | addi/slti ALU operation A op sign-ext
// S_I_WB    | write ALUOut into rt
// S_BEQ     | compare A-B, take branch on zero
// S_JUMP    | PC <= jump address
// S_JAL     | PC <= jump address, $31 <= PC
// S_JR      | PC <= A
// S_HALT    | absorbing, only reset leaves
module mips_mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_ld,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       selreg,
    output logic       selmem,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       halted
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EX,
        S_R_WB,
        S_I_EX,
        S_I_WB,
        S_BEQ,
        S_JUMP,
        S_JAL,
        S_JR,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0] r_alu;
    logic       r_func_ok;

    // R-type func decode; unknown funcs are flagged so DECODE can halt on them
    always_comb begin
        r_alu     = ALU_ADD;
        r_func_ok = 1'b1;
        case (func)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            FN_JR:   r_alu = ALU_ADD;
            default: r_func_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_ld      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        selreg     = 1'b0;
        selmem     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        halted     = 1'b0;

        // Holding reset keeps every output low, so an abandoned write cannot leak out
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_ld     = mem_ready;
                    if (mem_ready) begin
                        state_nxt = S_DECODE;
                    end
                end

                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                    case (opcode)
                        OP_LW, OP_SW:     state_nxt = S_MEM_ADR;
                        OP_R: begin
                            if (!r_func_ok) begin
                                state_nxt = S_HALT;
                            end else if (func == FN_JR) begin
                                state_nxt = S_JR;
                            end else begin
                                state_nxt = S_R_EX;
                            end
                        end
                        OP_ADDI, OP_SLTI: state_nxt = S_I_EX;
                        OP_BEQ:           state_nxt = S_BEQ;
                        OP_J:             state_nxt = S_JUMP;
                        OP_JAL:           state_nxt = S_JAL;
                        default:          state_nxt = S_HALT;
                    endcase
                end

                S_MEM_ADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                    state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end

                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_nxt = S_MEM_WB;
                    end
                end

                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end

                S_R_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b00;
                    alu_ctrl  = r_alu;
                    state_nxt = S_R_WB;
                end

                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_I_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                    state_nxt = S_I_WB;
                end

                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_BEQ: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b00;
                    alu_ctrl   = ALU_SUB;
                    pc_src     = 2'b01;
                    pc_ld      = zero;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_ld      = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                // PC already holds PC+4 from FETCH, which is the link value for $31
                S_JAL: begin
                    pc_src     = 2'b10;
                    pc_ld      = 1'b1;
                    reg_write  = 1'b1;
                    selreg     = 1'b1;
                    selmem     = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_JR: begin
                    pc_src     = 2'b11;
                    pc_ld      = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_HALT: begin
                    halted    = 1'b1;
                    state_nxt = S_HALT;
                end

                default: begin
                    state_nxt = S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: per-instruction expected cycle sequences built
// from the instruction semantics, compared against the DUT every cycle.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_ld, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, selreg, selmem, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       instr_done, halted;

    mips_mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_ld(pc_ld), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .selreg(selreg),
        .selmem(selmem), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .instr_done(instr_done), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_ld;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       selreg;
        logic       selmem;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       halted;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       mr;
        outs_t      exp;
    } rec_t;

    rec_t  plan[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t obs;

    assign obs = {pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  selreg, selmem, reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src,
                  instr_done, halted};

    task automatic add_rec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic mr, input outs_t o);
        rec_t r;
        r.op = op; r.fn = fn; r.z = z; r.mr = mr; r.exp = o;
        plan.push_back(r);
    endtask

    // mem_ready outside memory states is toggled to show it has no effect
    function automatic logic idle_mr();
        return (plan.size() % 2) == 1;
    endfunction

    // Builds the expected cycle list of one instruction. mw is the number of
    // mem_ready=0 cycles in the data-memory state, or HALT cycles for bad ops.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        outs_t o;
        logic [2:0] r_alu;
        logic r_ok;
        for (int i = 0; i <= fw; i++) begin
            o = '0; o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
            o.ir_write = (i == fw); o.pc_ld = (i == fw);
            add_rec(op, fn, z, i == fw, o);
        end
        o = '0; o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010;
        add_rec(op, fn, z, idle_mr(), o);

        r_ok = 1;
        case (fn)
            6'b100000: r_alu = 3'b010;
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b101010: r_alu = 3'b111;
            6'b001000: r_alu = 3'b000;
            default: begin r_alu = 3'b000; r_ok = 0; end
        endcase

        if (op == 6'b100011 || op == 6'b101011) begin
            o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010;
            add_rec(op, fn, z, idle_mr(), o);
            for (int i = 0; i <= mw; i++) begin
                o = '0; o.i_or_d = 1;
                if (op == 6'b100011) o.mem_read = 1;
                else begin o.mem_write = 1; o.instr_done = (i == mw); end
                add_rec(op, fn, z, i == mw, o);
            end
            if (op == 6'b100011) begin
                o = '0; o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1;
                add_rec(op, fn, z, idle_mr(), o);
            end
        end else if (op == 6'b000000 && r_ok && fn == 6'b001000) begin
            o = '0; o.pc_src = 2'b11; o.pc_ld = 1; o.instr_done = 1;
            add_rec(op, fn, z, idle_mr(), o);
        end else if (op == 6'b000000 && r_ok) begin
            o = '0; o.alu_src_a = 1; o.alu_ctrl = r_alu;
            add_rec(op, fn, z, idle_mr(), o);
            o = '0; o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1;
            add_rec(op, fn, z, idle_mr(), o);
        end else if (op == 6'b001000 || op == 6'b001010) begin
            o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
            o.alu_ctrl = (op == 6'b001010) ? 3'b111 : 3'b010;
            add_rec(op, fn, z, idle_mr(), o);
            o = '0; o.reg_write = 1; o.instr_done = 1;
            add_rec(op, fn, z, idle_mr(), o);
        end else if (op == 6'b000100) begin
            o = '0; o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
            o.pc_ld = z; o.instr_done = 1;
            add_rec(op, fn, z, idle_mr(), o);
        end else if (op == 6'b000010 || op == 6'b000011) begin
            o = '0; o.pc_src = 2'b10; o.pc_ld = 1; o.instr_done = 1;
            if (op == 6'b000011) begin o.reg_write = 1; o.selreg = 1; o.selmem = 1; end
            add_rec(op, fn, z, idle_mr(), o);
        end else begin
            for (int i = 0; i < mw; i++) begin
                o = '0; o.halted = 1;
                add_rec(op, fn, z, idle_mr(), o);
            end
        end
    endtask

    // Plays the plan one cycle per record. want_lat: cycles to the first
    // instr_done, -1 when none may occur, -2 to skip the latency check.
    task automatic run_plan(input string name, input int max_recs, input int want_lat);
        rec_t r;
        int n = 0;
        int lat = -1;
        while (plan.size() > 0 && n < max_recs) begin
            r = plan.pop_front();
            opcode = r.op; func = r.fn; zero = r.z; mem_ready = r.mr;
            #1;
            n_cmp++;
            if (obs !== r.exp) begin
                n_bad++;
                $display("FAIL %s cycle %0d: outputs got %h want %h", name, n + 1, obs, r.exp);
            end
            n++;
            if (instr_done === 1'b1 && lat < 0) lat = n;
            @(negedge clk);
        end
        plan.delete();
        if (want_lat != -2) begin
            n_cmp++;
            if (lat != want_lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic [5:0] r_funcs [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_all_zero", 32'(obs), 32'h0);
        check("reset_mem_read", 32'(mem_read), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        build(6'b000000, 6'b100000, 1'b0, 0, 0); run_plan("add", 100, 4);
        build(6'b100011, 6'b000000, 1'b1, 2, 3); run_plan("lw_wait", 100, 10);
        build(6'b100011, 6'b000000, 1'b0, 0, 0); run_plan("lw", 100, 5);
        build(6'b101011, 6'b000000, 1'b0, 0, 0); run_plan("sw", 100, 4);
        build(6'b101011, 6'b000000, 1'b0, 1, 2); run_plan("sw_wait", 100, 7);
        foreach (r_funcs[i]) begin
            build(6'b000000, r_funcs[i], 1'b0, 0, 0); run_plan("rtype", 100, 4);
        end
        build(6'b001000, 6'b000000, 1'b1, 0, 0); run_plan("addi", 100, 4);
        build(6'b001010, 6'b111111, 1'b0, 0, 0); run_plan("slti", 100, 4);
        build(6'b000100, 6'b000000, 1'b1, 0, 0); run_plan("beq_taken", 100, 3);
        build(6'b000100, 6'b000000, 1'b0, 0, 0); run_plan("beq_not", 100, 3);
        build(6'b000010, 6'b000000, 1'b0, 0, 0); run_plan("j", 100, 3);
        build(6'b000011, 6'b000000, 1'b0, 0, 0); run_plan("jal", 100, 3);
        build(6'b000000, 6'b001000, 1'b0, 0, 0); run_plan("jr", 100, 3);

        // reset while a store waits in MEM_WR
        build(6'b101011, 6'b000000, 1'b0, 0, 3); run_plan("sw_pre_rst", 4, -2);
        mem_ready = 1'b0;
        #1;
        check("mem_wr_before_rst", 32'(mem_write), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mem_wr_dropped", 32'(mem_write), 32'h0);
        check("rst_outputs_zero", 32'(obs), 32'h0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("rst_held_zero", 32'(obs), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        build(6'b001000, 6'b000000, 1'b0, 2, 0); run_plan("after_rst_addi", 100, 6);

        build(6'b111111, 6'b000000, 1'b0, 0, 6); run_plan("halt_op", 100, -1);
        check("halted_stays", 32'(halted), 32'h1);
        rst = 1'b0;
        #1;
        check("halt_rst_zero", 32'(obs), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        build(6'b000010, 6'b000000, 1'b0, 1, 0); run_plan("j_after_halt", 100, 4);

        build(6'b000000, 6'b000001, 1'b0, 0, 4); run_plan("halt_func", 100, -1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        build(6'b000000, 6'b100000, 1'b0, 0, 0); run_plan("add_after_halt", 100, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
